// File: rtl/mem_store_monitor.sv
// mem_store_monitor: watches the core data-memory store port, records every
// store in a first-word-fall-through trace FIFO and derives a pass / fail /
// timeout verdict from the store stream.
//
// Ports:
//   clk, reset                 rising-edge clock, async active-high reset
//   mem_write, data_adr,       core store strobe, address and data
//   write_data
//   trace_valid/trace_ready    head-of-FIFO handshake toward the debug reader
//   trace_adr, trace_data      oldest captured store
//   trace_count                FIFO occupancy, 0..DEPTH
//   overflow                   sticky: a store was dropped on a full FIFO
//   done, pass, fail, timeout  verdict flags (one-hot among pass/fail/timeout)
module mem_store_monitor #(
  parameter int unsigned DEPTH     = 8,
  parameter logic [31:0] PASS_ADR  = 32'd84,
  parameter logic [31:0] PASS_DATA = 32'd7,
  parameter logic [31:0] ALLOW_ADR = 32'd80,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_write,
  input  logic [31:0]              data_adr,
  input  logic [31:0]              write_data,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [31:0]              trace_adr,
  output logic [31:0]              trace_data,
  output logic [$clog2(DEPTH):0]   trace_count,
  output logic                     overflow,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  entry_t           mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q;
  logic             overflow_q, overflow_d;

  state_e           state_q, state_d;
  logic [TW-1:0]    cyc_q, cyc_d;
  logic             done_q, pass_q, fail_q, timeout_q;

  logic             full_c;
  logic             pop_c;
  logic             push_c;
  logic             drop_c;
  logic             store_pass_c;
  logic             store_fail_c;

  // FIFO control: a pop frees a slot in the same cycle, so push-while-full
  // is accepted whenever the reader pops concurrently.
  always_comb begin
    full_c     = (count_q == CW'(DEPTH));
    pop_c      = valid_q & trace_ready;
    push_c     = mem_write & (~full_c | pop_c);
    drop_c     = mem_write & full_c & ~pop_c;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop_c;
    if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= (count_d != '0);
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only visible while trace_valid=1.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= '{adr: data_adr, data: write_data};
  end

  // Verdict next-state: store-based verdicts take priority over timeout.
  always_comb begin
    store_pass_c = mem_write & (data_adr == PASS_ADR) & (write_data == PASS_DATA);
    store_fail_c = mem_write & (data_adr != ALLOW_ADR) & ~store_pass_c;
    state_d      = state_q;
    cyc_d        = cyc_q;
    case (state_q)
      ST_RUN: begin
        cyc_d = cyc_q + TW'(1);
        if (store_pass_c)                       state_d = ST_PASS;
        else if (store_fail_c)                  state_d = ST_FAIL;
        else if (cyc_q == TW'(TIMEOUT - 1))     state_d = ST_TIMEOUT;
      end
      default: begin
        state_d = state_q;
        cyc_d   = cyc_q;
      end
    endcase
  end

  // Verdict registers; flags are registered alongside the state they decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RUN;
      cyc_q     <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      done_q    <= (state_d != ST_RUN);
      pass_q    <= (state_d == ST_PASS);
      fail_q    <= (state_d == ST_FAIL);
      timeout_q <= (state_d == ST_TIMEOUT);
    end
  end

  assign trace_valid = valid_q;
  assign trace_adr   = mem_q[rd_ptr_q].adr;
  assign trace_data  = mem_q[rd_ptr_q].data;
  assign trace_count = count_q;
  assign overflow    = overflow_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_mem_store_monitor.sv
// Testbench for mem_store_monitor: directed store sequences, a queue-based
// reference model compared every cycle, plus literal spot checks.
module tb_mem_store_monitor;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 20;
  localparam int unsigned CW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_write = 1'b0;
  logic [31:0]   data_adr = '0;
  logic [31:0]   write_data = '0;
  logic          trace_ready = 1'b0;
  logic          trace_valid;
  logic [31:0]   trace_adr;
  logic [31:0]   trace_data;
  logic [CW-1:0] trace_count;
  logic          overflow, done, pass, fail, timeout;

  int vectors = 0;
  int errors  = 0;
  bit cmp_en  = 1'b0;

  mem_store_monitor #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .mem_write(mem_write), .data_adr(data_adr),
    .write_data(write_data), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_adr(trace_adr), .trace_data(trace_data), .trace_count(trace_count),
    .overflow(overflow), .done(done), .pass(pass), .fail(fail), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, verdict as a small enum-like int.
  logic [63:0] mq[$];
  bit          m_ovf = 1'b0;
  int          m_verdict = 0;   // 0 running, 1 pass, 2 fail, 3 timeout
  int          m_cycles = 0;    // cycles spent running since reset

  initial begin : model
    logic [63:0] ent;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mq.delete();
        m_ovf = 1'b0;
        m_verdict = 0;
        m_cycles = 0;
      end else begin
        if (mq.size() > 0 && trace_ready) ent = mq.pop_front();
        if (mem_write) begin
          if (mq.size() < DEPTH) mq.push_back({data_adr, write_data});
          else m_ovf = 1'b1;
        end
        if (m_verdict == 0) begin
          m_cycles++;
          if (mem_write && data_adr == 32'd84 && write_data == 32'd7) m_verdict = 1;
          else if (mem_write && data_adr != 32'd80) m_verdict = 2;
          else if (m_cycles == TIMEOUT) m_verdict = 3;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("valid", 64'(trace_valid), 64'(mq.size() != 0));
      chk("count", 64'(trace_count), 64'(mq.size()));
      if (mq.size() != 0) chk("head", {trace_adr, trace_data}, mq[0]);
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("done", 64'(done), 64'(m_verdict != 0));
      chk("pass", 64'(pass), 64'(m_verdict == 1));
      chk("fail", 64'(fail), 64'(m_verdict == 2));
      chk("timeout", 64'(timeout), 64'(m_verdict == 3));
    end
  end

  // All tasks start and end 2 time units after a rising edge.
  task automatic do_reset();
    reset = 1'b1; mem_write = 1'b0; trace_ready = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem_write = 1'b1; data_adr = a; write_data = d;
    @(posedge clk); #2;
    mem_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    cmp_en = 1'b1;
    chk("rst_valid", 64'(trace_valid), 64'd0);
    chk("rst_done", 64'({done, pass, fail, timeout, overflow}), 64'd0);
    reset = 1'b0;

    // Allowed store then pass store, reader always ready.
    trace_ready = 1'b1;
    store(32'd80, 32'd5);
    chk("s1_head", {trace_adr, trace_data}, {32'd80, 32'd5});
    chk("s1_done", 64'(done), 64'd0);
    store(32'd84, 32'd7);
    chk("s1_head2", {trace_adr, trace_data}, {32'd84, 32'd7});
    chk("s1_pass", 64'({done, pass, fail, timeout}), 64'b1100);
    idle(2);
    chk("s1_drained", 64'(trace_valid), 64'd0);

    // Bad address fails; later pass store cannot override.
    do_reset();
    store(32'd88, 32'd1);
    chk("s2_fail", 64'({done, pass, fail, timeout}), 64'b1010);
    store(32'd84, 32'd7);
    chk("s2_sticky", 64'({pass, fail}), 64'b01);

    // Wrong data at the pass address fails.
    do_reset();
    store(32'd84, 32'd6);
    chk("s3_fail", 64'({pass, fail}), 64'b01);

    // Pass store on the last running cycle beats timeout.
    do_reset();
    idle(TIMEOUT - 1);
    chk("s3_notyet", 64'(done), 64'd0);
    store(32'd84, 32'd7);
    chk("s3_pass_edge", 64'({pass, timeout}), 64'b10);

    // No stores: timeout exactly TIMEOUT cycles after release.
    do_reset();
    idle(TIMEOUT - 1);
    chk("s4_before", 64'(timeout), 64'd0);
    idle(1);
    chk("s4_timeout", 64'({done, pass, fail, timeout}), 64'b1001);
    idle(5);
    chk("s4_frozen", 64'(timeout), 64'd1);

    // Overflow: nine stores into an eight-deep FIFO, then drain.
    do_reset();
    for (int i = 0; i < 9; i++) store(32'd80, 32'(i));
    chk("s5_count", 64'(trace_count), 64'd8);
    chk("s5_ovf", 64'(overflow), 64'd1);
    for (int i = 0; i < 8; i++) begin
      chk("s5_drain", 64'(trace_data), 64'(i));
      trace_ready = 1'b1;
      @(posedge clk); #2;
      trace_ready = 1'b0;
    end
    chk("s5_empty", 64'(trace_valid), 64'd0);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 8; i++) store(32'd80, 32'(10 + i));
    trace_ready = 1'b1;
    store(32'd80, 32'd99);
    trace_ready = 1'b0;
    chk("s6_count", 64'(trace_count), 64'd8);
    chk("s6_ovf", 64'(overflow), 64'd0);
    chk("s6_head", 64'(trace_data), 64'd11);
    trace_ready = 1'b1;
    idle(7);
    chk("s6_last", 64'(trace_data), 64'd99);
    trace_ready = 1'b0;

    // Asynchronous reset mid-stream.
    store(32'd80, 32'd1);
    store(32'd88, 32'd2);
    reset = 1'b1;
    #1;
    chk("s7_async", 64'({trace_valid, overflow, done, pass, fail, timeout}), 64'd0);
    chk("s7_count", 64'(trace_count), 64'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
